// File: rtl/id_ex_control.sv
// Decode-stage control unit and ID/EX control pipeline register.
// Decodes InstrD into the main control signals and the ALU control code,
// registers them into EX, and detects load-use hazards that need an EX bubble.
module id_ex_control #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [XLEN-1:0] InstrD,
  input  logic            ValidD,
  input  logic            PCSrcE,
  output logic [1:0]      ImmSrcD,
  output logic            StallF,
  output logic            StallD,
  output logic            FlushD,
  output logic            RegWriteE,
  output logic [1:0]      ResultSrcE,
  output logic            MemWriteE,
  output logic            JumpE,
  output logic            BranchE,
  output logic            ALUSrcE,
  output logic [2:0]      ALUControlE,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E,
  output logic [4:0]      RdE,
  output logic            ValidE,
  output logic            IllegalE
);

  typedef enum logic [6:0] {
    OP_LW  = 7'b0000011,
    OP_SW  = 7'b0100011,
    OP_R   = 7'b0110011,
    OP_I   = 7'b0010011,
    OP_BEQ = 7'b1100011,
    OP_JAL = 7'b1101111
  } opcode_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } aluctl_e;

  opcode_e     op;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic [4:0]  rs1_d;
  logic [4:0]  rs2_d;
  logic [4:0]  rd_d;
  logic        unused_instr_bits;

  assign op       = opcode_e'(InstrD[6:0]);
  assign funct3   = InstrD[14:12];
  assign funct7b5 = InstrD[30];
  assign rs1_d    = InstrD[19:15];
  assign rs2_d    = InstrD[24:20];
  assign rd_d     = InstrD[11:7];
  assign unused_instr_bits = ^{InstrD[31], InstrD[29:25]};

  logic        regwrite_d;
  logic [1:0]  resultsrc_d;
  logic        memwrite_d;
  logic        jump_d;
  logic        branch_d;
  logic        alusrc_d;
  logic [1:0]  immsrc_d;
  aluop_e      aluop_d;
  aluctl_e     aluctl_d;
  logic        illegal_d;

  // Main decode plus ALU decode; illegal encodings collapse to all-zero controls
  always_comb begin
    regwrite_d  = 1'b0;
    resultsrc_d = 2'b00;
    memwrite_d  = 1'b0;
    jump_d      = 1'b0;
    branch_d    = 1'b0;
    alusrc_d    = 1'b0;
    immsrc_d    = 2'b00;
    aluop_d     = ALUOP_ADD;
    aluctl_d    = ALU_ADD;
    illegal_d   = 1'b0;
    if (ValidD) begin
      case (op)
        OP_LW: begin
          regwrite_d  = 1'b1;
          alusrc_d    = 1'b1;
          resultsrc_d = 2'b01;
        end
        OP_SW: begin
          memwrite_d = 1'b1;
          immsrc_d   = 2'b01;
          alusrc_d   = 1'b1;
        end
        OP_R: begin
          regwrite_d = 1'b1;
          aluop_d    = ALUOP_FUNCT;
        end
        OP_I: begin
          regwrite_d = 1'b1;
          alusrc_d   = 1'b1;
          aluop_d    = ALUOP_FUNCT;
        end
        OP_BEQ: begin
          branch_d = 1'b1;
          immsrc_d = 2'b10;
          aluop_d  = ALUOP_SUB;
        end
        OP_JAL: begin
          regwrite_d  = 1'b1;
          jump_d      = 1'b1;
          immsrc_d    = 2'b11;
          resultsrc_d = 2'b10;
        end
        default: illegal_d = 1'b1;
      endcase

      case (aluop_d)
        ALUOP_SUB: aluctl_d = ALU_SUB;
        ALUOP_FUNCT: begin
          case (funct3)
            3'b000:  aluctl_d = (InstrD[5] & funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  aluctl_d = ALU_SLT;
            3'b110:  aluctl_d = ALU_OR;
            3'b111:  aluctl_d = ALU_AND;
            default: illegal_d = 1'b1;
          endcase
        end
        default: aluctl_d = ALU_ADD;
      endcase

      if (illegal_d) begin
        regwrite_d  = 1'b0;
        resultsrc_d = 2'b00;
        memwrite_d  = 1'b0;
        jump_d      = 1'b0;
        branch_d    = 1'b0;
        alusrc_d    = 1'b0;
        immsrc_d    = 2'b00;
        aluctl_d    = ALU_ADD;
      end
    end
  end

  assign ImmSrcD = immsrc_d;

  logic lw_stall;
  logic flush_e;

  // Load-use hazard: a load in EX whose rd feeds either source of the D instruction
  always_comb begin
    lw_stall = ValidD & ValidE & (ResultSrcE == 2'b01) & (RdE != 5'd0) &
               ((RdE == rs1_d) | (RdE == rs2_d));
    flush_e  = lw_stall | PCSrcE;
  end

  assign StallF = lw_stall;
  assign StallD = lw_stall;
  assign FlushD = PCSrcE;

  // ID/EX register: bubble on reset or flush, otherwise load the decoded slot
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      RegWriteE   <= 1'b0;
      ResultSrcE  <= '0;
      MemWriteE   <= 1'b0;
      JumpE       <= 1'b0;
      BranchE     <= 1'b0;
      ALUSrcE     <= 1'b0;
      ALUControlE <= '0;
      Rs1E        <= '0;
      Rs2E        <= '0;
      RdE         <= '0;
      ValidE      <= 1'b0;
      IllegalE    <= 1'b0;
    end else if (flush_e) begin
      RegWriteE   <= 1'b0;
      ResultSrcE  <= '0;
      MemWriteE   <= 1'b0;
      JumpE       <= 1'b0;
      BranchE     <= 1'b0;
      ALUSrcE     <= 1'b0;
      ALUControlE <= '0;
      Rs1E        <= '0;
      Rs2E        <= '0;
      RdE         <= '0;
      ValidE      <= 1'b0;
      IllegalE    <= 1'b0;
    end else begin
      RegWriteE   <= regwrite_d;
      ResultSrcE  <= resultsrc_d;
      MemWriteE   <= memwrite_d;
      JumpE       <= jump_d;
      BranchE     <= branch_d;
      ALUSrcE     <= alusrc_d;
      ALUControlE <= aluctl_d;
      Rs1E        <= rs1_d;
      Rs2E        <= rs2_d;
      RdE         <= rd_d;
      ValidE      <= ValidD;
      IllegalE    <= illegal_d;
    end
  end

endmodule

// File: tb/tb_id_ex_control.sv
// Self-checking bench for id_ex_control: directed scenarios followed by
// randomized instruction streams, checked against a rule-level reference model.
module tb_id_ex_control;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] InstrD;
  logic        ValidD;
  logic        PCSrcE;
  logic [1:0]  ImmSrcD;
  logic        StallF, StallD, FlushD;
  logic        RegWriteE;
  logic [1:0]  ResultSrcE;
  logic        MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [2:0]  ALUControlE;
  logic [4:0]  Rs1E, Rs2E, RdE;
  logic        ValidE, IllegalE;

  id_ex_control #(.XLEN(32)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .InstrD      (InstrD),
    .ValidD      (ValidD),
    .PCSrcE      (PCSrcE),
    .ImmSrcD     (ImmSrcD),
    .StallF      (StallF),
    .StallD      (StallD),
    .FlushD      (FlushD),
    .RegWriteE   (RegWriteE),
    .ResultSrcE  (ResultSrcE),
    .MemWriteE   (MemWriteE),
    .JumpE       (JumpE),
    .BranchE     (BranchE),
    .ALUSrcE     (ALUSrcE),
    .ALUControlE (ALUControlE),
    .Rs1E        (Rs1E),
    .Rs2E        (Rs2E),
    .RdE         (RdE),
    .ValidE      (ValidE),
    .IllegalE    (IllegalE)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       regwrite;
    logic [1:0] resultsrc;
    logic       memwrite;
    logic       jump;
    logic       branch;
    logic       alusrc;
    logic [2:0] alu;
    logic [1:0] immsrc;
    logic       valid;
    logic       illegal;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } ctl_t;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  ctl_t        exp_e;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference decode straight from the instruction-set rules
  function automatic ctl_t ref_decode(input logic [31:0] i, input logic v);
    ctl_t       c;
    ctl_t       z;
    logic [6:0] op;
    logic [2:0] f3;
    logic       legal;
    c       = '0;
    c.rs1   = i[19:15];
    c.rs2   = i[24:20];
    c.rd    = i[11:7];
    c.valid = v;
    if (!v) return c;
    op    = i[6:0];
    f3    = i[14:12];
    legal = 1'b1;
    if (op == 7'b0000011) begin
      c.regwrite = 1; c.alusrc = 1; c.resultsrc = 2'b01; c.alu = 3'd0;
    end else if (op == 7'b0100011) begin
      c.memwrite = 1; c.alusrc = 1; c.immsrc = 2'b01; c.alu = 3'd0;
    end else if (op == 7'b0110011 || op == 7'b0010011) begin
      c.regwrite = 1;
      c.alusrc   = (op == 7'b0010011);
      if (f3 == 3'b000)      c.alu = (op == 7'b0110011 && i[30]) ? 3'd1 : 3'd0;
      else if (f3 == 3'b010) c.alu = 3'd5;
      else if (f3 == 3'b110) c.alu = 3'd3;
      else if (f3 == 3'b111) c.alu = 3'd2;
      else legal = 1'b0;
    end else if (op == 7'b1100011) begin
      c.branch = 1; c.immsrc = 2'b10; c.alu = 3'd1;
    end else if (op == 7'b1101111) begin
      c.regwrite = 1; c.jump = 1; c.immsrc = 2'b11; c.resultsrc = 2'b10;
    end else begin
      legal = 1'b0;
    end
    if (!legal) begin
      z         = '0;
      z.rs1     = c.rs1;
      z.rs2     = c.rs2;
      z.rd      = c.rd;
      z.valid   = 1'b1;
      z.illegal = 1'b1;
      c         = z;
    end
    return c;
  endfunction

  task automatic check_e(input string tag);
    chk({tag, "_ctlE"},
        {19'd0, RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUSrcE, ALUControlE, ValidE, IllegalE},
        {19'd0, exp_e.regwrite, exp_e.resultsrc, exp_e.memwrite, exp_e.jump, exp_e.branch,
         exp_e.alusrc, exp_e.alu, exp_e.valid, exp_e.illegal});
    chk({tag, "_idxE"}, {17'd0, Rs1E, Rs2E, RdE}, {17'd0, exp_e.rs1, exp_e.rs2, exp_e.rd});
  endtask

  // One clock cycle: drive D, check combinational outputs, then check EX after the edge
  task automatic cyc(input logic [31:0] instr, input logic v, input logic pc);
    ctl_t dec;
    logic st;
    InstrD = instr;
    ValidD = v;
    PCSrcE = pc;
    #3;
    dec = ref_decode(instr, v);
    st  = v && exp_e.valid && exp_e.resultsrc == 2'b01 && exp_e.rd != 0 &&
          (exp_e.rd == instr[19:15] || exp_e.rd == instr[24:20]);
    chk("hazard", {29'd0, StallF, StallD, FlushD}, {29'd0, st, st, pc});
    chk("immsrcD", {30'd0, ImmSrcD}, {30'd0, dec.immsrc});
    @(posedge clk);
    #1;
    exp_e = (st || pc) ? ctl_t'('0) : dec;
    check_e("cyc");
  endtask

  // Asynchronous reset pulse placed between clock edges
  task automatic async_reset();
    reset_n = 1'b0;
    #2;
    exp_e = '0;
    check_e("rst");
    #2;
    reset_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] i;
    i = $urandom;
    case ($urandom_range(0, 7))
      0: i[6:0] = 7'b0000011;
      1: i[6:0] = 7'b0100011;
      2: i[6:0] = 7'b0110011;
      3: i[6:0] = 7'b0010011;
      4: i[6:0] = 7'b1100011;
      5: i[6:0] = 7'b1101111;
      6: i[6:0] = 7'b0000011;
      default: ;
    endcase
    if ($urandom_range(0, 3) != 0) begin
      i[11:7]  = 5'($urandom_range(0, 7));
      i[19:15] = 5'($urandom_range(0, 7));
      i[24:20] = 5'($urandom_range(0, 7));
    end
    if ($urandom_range(0, 1) == 1) i[14:12] = ($urandom_range(0, 1) == 1) ? 3'b000 : 3'b110;
    return i;
  endfunction

  initial begin
    reset_n = 1'b0;
    InstrD  = '0;
    ValidD  = 1'b0;
    PCSrcE  = 1'b0;
    exp_e   = '0;
    #12;
    check_e("por");
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // add then sub
    cyc(32'h002081B3, 1, 0);
    chk("add_alu", {29'd0, ALUControlE}, 32'd0);
    chk("add_rd", {27'd0, RdE}, 32'd3);
    // mid-stream reset with RegWriteE=1
    chk("pre_rst_rw", {31'd0, RegWriteE}, 32'd1);
    async_reset();
    cyc(32'h402081B3, 1, 0);
    chk("sub_alu", {29'd0, ALUControlE}, 32'd1);
    chk("sub_rw", {29'd0, RegWriteE, ALUSrcE, ValidE}, 32'b101);

    // load-use: lw x5 then add x6,x5,x7
    cyc(32'h0000A283, 1, 0);
    InstrD = 32'h00728333; ValidD = 1; PCSrcE = 0;
    #1;
    chk("lwuse_stall", {30'd0, StallF, StallD}, 32'b11);
    cyc(32'h00728333, 1, 0);
    chk("lwuse_bubble", {31'd0, ValidE}, 32'd0);
    cyc(32'h00728333, 1, 0);
    chk("lwuse_rs1", {27'd0, Rs1E}, 32'd5);
    // lw x0 -> no stall
    cyc(32'h0000A003, 1, 0);
    InstrD = 32'h00028333;
    #1;
    chk("lwx0_nostall", {31'd0, StallF}, 32'd0);
    cyc(32'h00028333, 1, 0);

    // beq with and without a taken redirect
    cyc(32'h00208063, 1, 1);
    chk("beq_flush", {30'd0, BranchE, ValidE}, 32'd0);
    cyc(32'h00208063, 1, 0);
    chk("beq_ex", {28'd0, BranchE, ALUControlE}, 32'b1001);

    // illegal opcode and illegal R-type funct3
    cyc(32'hFFFFFFFF, 1, 0);
    chk("ill_op", {26'd0, IllegalE, RegWriteE, MemWriteE, BranchE, JumpE, ValidE}, 32'b100001);
    cyc(32'h002091B3, 1, 0);
    chk("ill_f3", {26'd0, IllegalE, RegWriteE, MemWriteE, BranchE, JumpE, ValidE}, 32'b100001);

    // slti, ori, andi
    cyc(32'h0020A193, 1, 0);
    chk("slti", {28'd0, ALUSrcE, ALUControlE}, 32'b1101);
    cyc(32'h0020E193, 1, 0);
    chk("ori", {28'd0, ALUSrcE, ALUControlE}, 32'b1011);
    cyc(32'h0020F193, 1, 0);
    chk("andi", {28'd0, ALUSrcE, ALUControlE}, 32'b1010);

    // randomized stream
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) async_reset();
      cyc(rand_instr(), ($urandom_range(0, 9) != 0), ($urandom_range(0, 9) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
